// File: rtl/rv32i_mem_arbiter_if.sv
// Memory-side bus of the RV32I fetch/data arbiter.
// Avalon-style single-port bus: master is the arbiter, slave is memory.
interface rv32i_mem_arbiter_if;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_readdata;
  logic        mem_waitrequest;

  modport master (
    output mem_addr,
    output mem_read,
    output mem_write,
    output mem_writedata,
    output mem_byteenable,
    input  mem_readdata,
    input  mem_waitrequest
  );

  modport slave (
    input  mem_addr,
    input  mem_read,
    input  mem_write,
    input  mem_writedata,
    input  mem_byteenable,
    output mem_readdata,
    output mem_waitrequest
  );
endinterface

// File: rtl/rv32i_mem_arbiter.sv
// Fetch/data arbiter for one shared memory port.
// Data wins; a starvation counter forces fetch after STARVE_LIMIT data grants.
module rv32i_mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ifetch_req,
  input  logic [31:0] ifetch_addr,
  output logic [31:0] ifetch_rdata,
  output logic        ifetch_valid,
  input  logic        dmem_load,
  input  logic        dmem_store,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_be,
  output logic [31:0] dmem_rdata,
  output logic        dmem_valid,
  output logic        stall,
  rv32i_mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RDWAIT,
    RESP
  } state_t;

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  state_t      state_q;
  state_t      state_d;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        wr_q;
  logic        sel_d_q;
  logic [2:0]  starve_q;
  logic [31:0] if_rdata_q;
  logic [31:0] d_rdata_q;

  logic data_req;
  logic force_if;
  logic gnt_d;
  logic gnt_i;
  logic grant;
  logic unused_addr_bits;

  assign data_req = dmem_load | dmem_store;
  assign force_if = ifetch_req && (starve_q == LIMIT);
  assign gnt_d    = data_req && !force_if;
  assign gnt_i    = ifetch_req && !gnt_d;
  assign grant    = (state_q == IDLE) && (gnt_d || gnt_i);

  assign unused_addr_bits = ^{dmem_addr[1:0], ifetch_addr[1:0]};

  // Next-state logic for the bus sequencer
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (gnt_d || gnt_i) state_d = BUS;
      BUS:     if (!bus.mem_waitrequest)
                 state_d = wr_q ? RESP : RDWAIT;
      RDWAIT:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any access in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Latch the winning request and track data grants that bypass a waiting fetch
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      wr_q     <= 1'b0;
      sel_d_q  <= 1'b0;
      starve_q <= '0;
    end else if (grant) begin
      sel_d_q <= gnt_d;
      wr_q    <= gnt_d && dmem_store;
      addr_q  <= gnt_d ? {dmem_addr[31:2], 2'b00}
                       : {ifetch_addr[31:2], 2'b00};
      wdata_q <= gnt_d ? dmem_wdata : '0;
      be_q    <= (gnt_d && dmem_store) ? dmem_be : 4'hf;
      if (gnt_d && ifetch_req) begin
        if (starve_q != LIMIT) starve_q <= starve_q + 3'd1;
      end else begin
        starve_q <= '0;
      end
    end
  end

  // Capture read data for whichever requester owns the access
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else if (state_q == RDWAIT) begin
      if (sel_d_q) d_rdata_q  <= bus.mem_readdata;
      else         if_rdata_q <= bus.mem_readdata;
    end
  end

  assign bus.mem_addr       = addr_q;
  assign bus.mem_writedata  = wdata_q;
  assign bus.mem_byteenable = be_q;
  assign bus.mem_read       = (state_q == BUS) && !wr_q;
  assign bus.mem_write      = (state_q == BUS) && wr_q;

  assign ifetch_rdata = if_rdata_q;
  assign dmem_rdata   = d_rdata_q;
  assign ifetch_valid = (state_q == RESP) && !sel_d_q;
  assign dmem_valid   = (state_q == RESP) && sel_d_q;
  assign stall        = data_req && !dmem_valid;

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Bench for rv32i_mem_arbiter: vector table, scoreboard,
// priority, starvation and mid-transfer reset sequences.
module tb_rv32i_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ifetch_req = 1'b0;
  logic [31:0] ifetch_addr = '0;
  logic [31:0] ifetch_rdata;
  logic        ifetch_valid;
  logic        dmem_load = 1'b0;
  logic        dmem_store = 1'b0;
  logic [31:0] dmem_addr = '0;
  logic [31:0] dmem_wdata = '0;
  logic [3:0]  dmem_be = '0;
  logic [31:0] dmem_rdata;
  logic        dmem_valid;
  logic        stall;

  rv32i_mem_arbiter_if bus();

  rv32i_mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ifetch_req   (ifetch_req),
    .ifetch_addr  (ifetch_addr),
    .ifetch_rdata (ifetch_rdata),
    .ifetch_valid (ifetch_valid),
    .dmem_load    (dmem_load),
    .dmem_store   (dmem_store),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_be      (dmem_be),
    .dmem_rdata   (dmem_rdata),
    .dmem_valid   (dmem_valid),
    .stall        (stall),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%08h exp=%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    if (i == 'h41) return 32'h0051_8493;
    return (32'(i) * 32'h0101_0101) ^ 32'h5A5A_0000;
  endfunction

  // Slave memory with programmable wait states
  logic [31:0] mem [0:255];
  logic [31:0] shadow [0:255];
  int ws_cfg = 0;
  int wcnt;
  logic strobe;

  assign strobe = bus.mem_read | bus.mem_write;
  assign bus.mem_waitrequest = strobe && (wcnt < ws_cfg);

  always @(posedge clk) begin
    if (!reset_n) begin
      wcnt <= 0;
      bus.mem_readdata <= '0;
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else begin
      if (strobe) wcnt <= bus.mem_waitrequest ? wcnt + 1 : 0;
      if (bus.mem_read && !bus.mem_waitrequest)
        bus.mem_readdata <= mem[bus.mem_addr[9:2]];
      if (bus.mem_write && !bus.mem_waitrequest)
        for (int b = 0; b < 4; b++)
          if (bus.mem_byteenable[b])
            mem[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_writedata[8*b +: 8];
    end
  end

  // Scoreboard of completions in expected order
  typedef struct {
    logic        is_f;
    logic        chk_rd;
    logic [31:0] rdata;
  } exp_t;

  exp_t sbq[$];
  exp_t e;

  always @(negedge clk) begin
    if (reset_n && (ifetch_valid || dmem_valid)) begin
      chk("one_valid", {31'b0, ifetch_valid & dmem_valid}, 32'd0);
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow act=valid exp=none");
      end else begin
        e = sbq.pop_front();
        chk("sb_who", {31'b0, ifetch_valid}, {31'b0, e.is_f});
        if (e.chk_rd)
          chk("sb_rdata", ifetch_valid ? ifetch_rdata : dmem_rdata,
              e.rdata);
      end
    end
  end

  typedef struct {
    logic        f;
    logic        ld;
    logic        st;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          ws;
    int          lat;
  } vec_t;

  vec_t tbl[10];

  task automatic drop_reqs();
    ifetch_req = 1'b0;
    dmem_load  = 1'b0;
    dmem_store = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_addr"}, bus.mem_addr, 32'd0);
    chk({tag, "_strb"}, {30'b0, bus.mem_read, bus.mem_write}, 32'd0);
    chk({tag, "_wd"}, bus.mem_writedata | {28'b0, bus.mem_byteenable},
        32'd0);
    chk({tag, "_vld"}, {29'b0, ifetch_valid, dmem_valid, stall}, 32'd0);
    chk({tag, "_rd"}, ifetch_rdata | dmem_rdata, 32'd0);
  endtask

  task automatic push_exp(input logic f, input logic rd,
                          input logic [31:0] a);
    exp_t x;
    x.is_f   = f;
    x.chk_rd = rd;
    x.rdata  = rd ? shadow[a[9:2]] : 32'd0;
    sbq.push_back(x);
  endtask

  task automatic run_vec(input int n, input vec_t v);
    int lat;
    int strb;
    logic is_d;
    is_d = v.ld | v.st;
    @(negedge clk);
    ws_cfg      = v.ws;
    ifetch_req  = v.f;
    ifetch_addr = v.addr;
    dmem_load   = v.ld;
    dmem_store  = v.st;
    dmem_addr   = v.addr;
    dmem_wdata  = v.wdata;
    dmem_be     = v.be;
    if (v.st) begin
      push_exp(1'b0, 1'b0, v.addr);
      for (int b = 0; b < 4; b++)
        if (v.be[b]) shadow[v.addr[9:2]][8*b +: 8] = v.wdata[8*b +: 8];
    end else begin
      push_exp(v.f, 1'b1, v.addr);
    end
    #1;
    chk($sformatf("v%0d_stall_n", n), {31'b0, stall}, {31'b0, is_d});
    @(negedge clk);
    chk($sformatf("v%0d_addr", n), bus.mem_addr, {v.addr[31:2], 2'b00});
    chk($sformatf("v%0d_rd", n), {31'b0, bus.mem_read},
        {31'b0, v.f | (v.ld & ~v.st)});
    chk($sformatf("v%0d_wr", n), {31'b0, bus.mem_write}, {31'b0, v.st});
    chk($sformatf("v%0d_be", n), {28'b0, bus.mem_byteenable},
        {28'b0, v.st ? v.be : 4'hf});
    if (v.st)
      chk($sformatf("v%0d_wd", n), bus.mem_writedata, v.wdata);
    lat  = 1;
    strb = 1;
    while (!(ifetch_valid || dmem_valid) && lat < 40) begin
      if (is_d) chk($sformatf("v%0d_stall", n), {31'b0, stall}, 32'd1);
      @(negedge clk);
      lat++;
      if (strobe) strb++;
    end
    chk($sformatf("v%0d_lat", n), lat, v.lat);
    chk($sformatf("v%0d_strb", n), strb, v.ws + 1);
    if (is_d) chk($sformatf("v%0d_stall_v", n), {31'b0, stall}, 32'd0);
    drop_reqs();
  endtask

  initial begin
    int t;
    int dcnt;
    logic seen;

    for (int i = 0; i < 256; i++) shadow[i] = init_word(i);

    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0104, 32'h0, 4'h0, 0, 3};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'h0, 0, 3};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 32'h0000_2002, 32'hAB00_0000, 4'b1000, 2, 4};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'h0, 1, 4};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 32'h0000_0108, 32'h0, 4'h0, 3, 6};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 32'h0000_0300, 32'h1234_5678, 4'hf, 0, 2};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'h0, 0, 3};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 32'h0000_0304, 32'hCAFE_BABE, 4'b0101, 1, 3};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 32'h0000_0306, 32'h0, 4'h0, 0, 3};
    tbl[9] = '{1'b1, 1'b0, 1'b0, 32'h0000_00FC, 32'h0, 4'h0, 2, 5};

    // Power-on reset
    repeat (3) @(negedge clk);
    chk_zero("por");
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("idle");

    for (int i = 0; i < 10; i++) run_vec(i, tbl[i]);

    // Priority: data first, fetch in the following IDLE
    @(negedge clk);
    ws_cfg      = 0;
    ifetch_req  = 1'b1;
    ifetch_addr = 32'h0000_010C;
    dmem_load   = 1'b1;
    dmem_addr   = 32'h0000_0300;
    push_exp(1'b0, 1'b1, 32'h300);
    push_exp(1'b1, 1'b1, 32'h10C);
    @(negedge clk);
    chk("prio_first", bus.mem_addr, 32'h0000_0300);
    t = 0;
    while (!dmem_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("prio_dvalid", {31'b0, dmem_valid}, 32'd1);
    dmem_load = 1'b0;
    repeat (2) @(negedge clk);
    chk("prio_f_addr", bus.mem_addr, 32'h0000_010C);
    chk("prio_f_rd", {31'b0, bus.mem_read}, 32'd1);
    t = 0;
    while (!ifetch_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("prio_fvalid", {31'b0, ifetch_valid}, 32'd1);
    ifetch_req = 1'b0;

    // Starvation: continuous loads with fetch pending
    @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) push_exp(1'b0, 1'b1, 32'h300);
      push_exp(1'b1, 1'b1, r == 0 ? 32'h110 : 32'h114);
    end
    ifetch_req  = 1'b1;
    ifetch_addr = 32'h0000_0110;
    dmem_load   = 1'b1;
    dmem_addr   = 32'h0000_0300;
    for (int r = 0; r < 2; r++) begin
      dcnt = 0;
      seen = 1'b0;
      t = 0;
      while (!seen && t < 100) begin
        @(negedge clk);
        t++;
        if (dmem_valid) dcnt++;
        if (ifetch_valid) seen = 1'b1;
      end
      chk($sformatf("starve%0d_fetch", r), {31'b0, seen}, 32'd1);
      chk($sformatf("starve%0d_dcnt", r), dcnt, 32'd4);
      if (r == 0) ifetch_addr = 32'h0000_0114;
    end
    drop_reqs();

    // Reset in the middle of a read held by waitrequest
    @(negedge clk);
    ws_cfg    = 5;
    dmem_load = 1'b1;
    dmem_addr = 32'h0000_0300;
    @(negedge clk);
    chk("mid_rd_pre", {31'b0, bus.mem_read}, 32'd1);
    #2;
    reset_n   = 1'b0;
    dmem_load = 1'b0;
    #1;
    chk_zero("mid_rst");
    repeat (2) begin
      @(negedge clk);
      chk("mid_no_vld", {30'b0, ifetch_valid, dmem_valid}, 32'd0);
    end
    ws_cfg  = 0;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("mid_post");

    chk("sb_drain", sbq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv32i_mem_arbiter.md
# rv32i_mem_arbiter

Shares one single-port Avalon-style memory bus between the instruction-fetch requester and the ALU load/store requester of the RV32I core. Data accesses have priority, and a starvation counter guarantees fetch progress. The block stalls the pipeline while a data access is outstanding. It sits between the fetch/ALU stages and the system memory.

## Interface
- STARVE_LIMIT, 4: consecutive data grants allowed, with fetch waiting, before fetch is forced (1–7).
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- ifetch_req  in  1  fetch request; held until ifetch_valid
- ifetch_addr  in  32  fetch word address; stable while ifetch_req
- ifetch_rdata  out  32  fetched instruction; valid with ifetch_valid
- ifetch_valid  out  1  one-cycle completion pulse for fetch
- dmem_load  in  1  load request; held until dmem_valid
- dmem_store  in  1  store request; held until dmem_valid
- dmem_addr  in  32  word-aligned data address (bits [1:0] ignored)
- dmem_wdata  in  32  lane-shifted store data
- dmem_be  in  4  store byte enables
- dmem_rdata  out  32  raw load word; valid with dmem_valid
- dmem_valid  out  1  one-cycle completion pulse for load or store
- stall  out  1  pipeline stall
- mem_addr  out  32  bus address, {addr[31:2],2'b00}
- mem_read  out  1  bus read strobe
- mem_write  out  1  bus write strobe
- mem_writedata  out  32  bus write data
- mem_byteenable  out  4  bus byte enables (4'b1111 for reads)
- mem_readdata  in  32  read data; valid the cycle after read acceptance
- mem_waitrequest  in  1  slave back-pressure; strobes and data must hold while high

## Operation
- FSM states: IDLE, BUS, RDWAIT, RESP.
- **IDLE:** arbitrate among present requests.
  - No requests: stay in IDLE.
  - Grant goes to data if dmem_load|dmem_store. Exception: ifetch_req is high and starve_cnt == STARVE_LIMIT, in which case grant goes to fetch.
  - Otherwise grant goes to fetch if ifetch_req.
  - On grant: register address, write data and byte enables, and the op type; go to BUS.
- **Simultaneous dmem_load and dmem_store:** treated as a store.
- **BUS:** mem_read or mem_write is asserted from registered values, held while mem_waitrequest=1.
  - Accepted write (waitrequest=0) goes to RESP.
  - Accepted read goes to RDWAIT.
- **RDWAIT:** capture mem_readdata into the granted requester's rdata register; go to RESP.
- **RESP:** pulse ifetch_valid or dmem_valid, whichever was granted; go to IDLE.
  - Requesters drop or replace their request in the cycle after the valid pulse.
  - Requests are not sampled in RESP.
- **starve_cnt** (3-bit), updated at each IDLE grant:
  - Data grant while ifetch_req=1: increment, saturating at STARVE_LIMIT.
  - Fetch grant, or any grant with ifetch_req=0: clear.
- **stall** = (dmem_load|dmem_store) & ~dmem_valid. Combinational, so it asserts in the same cycle the request appears.
- ifetch_rdata and dmem_rdata hold their value until the next read for that requester completes.

## Timing
- **Reset values:** every output 0; state IDLE; starve_cnt 0; rdata registers 0.
- **Reset assertion mid-transfer:** mem_read and mem_write drop asynchronously and no valid pulse is generated for the aborted access. Requesters re-issue after reset.
- **Read, zero wait:** request seen in IDLE at cycle n; BUS at n+1; RDWAIT at n+2; valid at n+3.
- **Write, zero wait:** request at n; BUS at n+1; valid at n+2.
- Each cycle of mem_waitrequest=1 in BUS adds exactly one cycle of latency.
- mem_* outputs are registered and stable for the whole BUS state. They deassert (strobes 0) in every other state.
- **Back-to-back:** minimum IDLE-to-IDLE turnaround is 4 cycles for a read and 3 for a write. New grants occur only in IDLE.
- A request arriving during BUS, RDWAIT or RESP waits for the next IDLE. Only stall reflects it immediately.

## Test plan
- **Reset/idle:** reset_n low mid-BUS with mem_read=1 → mem_read=0 immediately, no valid pulse, all outputs 0; after release with no requests, outputs stay 0.
- **Single fetch:** ifetch_req, ifetch_addr=0x0000_0104, mem_readdata=0x0051_8493 → mem_addr=0x104 and mem_read=1 at n+1; ifetch_valid pulse with ifetch_rdata=0x0051_8493 at n+3.
- **Store with wait states:** dmem_store, addr=0x2002, wdata=0xAB00_0000, be=4'b1000, waitrequest high for 2 cycles → mem_addr=0x2000, strobes held 3 cycles, dmem_valid at n+4; stall=1 from n through n+3 and 0 at n+4.
- **Priority:** load and fetch requested together → data granted first; fetch granted in the next IDLE after the load's RESP.
- **Starvation:** ifetch_req held with continuous data requests, STARVE_LIMIT=4 → four data grants, then a fetch grant, then starve_cnt back at 0.
- **Load+store collision:** both dmem_load and dmem_store high → mem_write=1, mem_read=0, single dmem_valid pulse.
